// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : LSB-first bit-serial unsigned subtractor (in1 - in2) with a
//            start/busy/done handshake and registered diff/borrow outputs.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             br_q,     br_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;

  logic             bit_d;
  logic             br_next;

  // Full subtractor built from two half-subtractor stages plus the borrow flop.
  assign bit_d   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Publish only the finished word so partial results never leak out.
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = br_next;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Scoreboard bench for serial_subtractor (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in1    (in1),
    .in2    (in2),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             b;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   busy_run = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: pops an expectation whenever done is presented.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy && done) check("busy_and_done", 1, 0);
      if (busy) busy_run++;
      if (done) begin
        exp_t e;
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("diff",     int'(diff),   int'(e.d));
          check("borrow",   int'(borrow), int'(e.b));
          check("latency",  cyc - e.acc,  WIDTH);
          check("busy_len", busy_run,     WIDTH);
        end
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Issue one operation from IDLE; expectation pushed when it is accepted.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [WIDTH-1:0] ed, input logic eb, input bit push);
    exp_t e;
    wait_idle();
    in1   = x;
    in2   = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = 'x;
    in2   = 'x;
    e.d   = ed;
    e.b   = eb;
    e.acc = cyc;
    if (push) exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_diff",   int'(diff),   0);
    check("rst_borrow", int'(borrow), 0);
    reset = 1'b0;

    // Basic, underflow and boundary vectors
    run_op(8'd5, 8'd3, 8'd2, 1'b0, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    check("hold_diff",   int'(diff),   2);
    check("hold_borrow", int'(borrow), 0);
    run_op(8'd3,  8'd5,  8'hFE, 1'b1, 1'b1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
    run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);
    wait_drain();

    // start while busy must be ignored
    run_op(8'd10, 8'd4, 8'd6, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    in1   = 8'd1;
    in2   = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (WIDTH + 4) @(negedge clk);
    check("ignored_start_diff", int'(diff), 6);

    // Reset mid-operation
    run_op(8'd9, 8'd2, 8'd7, 1'b0, 1'b1);
    wait_drain();
    check("pre_abort_diff", int'(diff), 7);
    run_op(8'd20, 8'd5, 8'd15, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",   int'(busy),   0);
    check("abort_done",   int'(done),   0);
    check("abort_diff",   int'(diff),   0);
    check("abort_borrow", int'(borrow), 0);
    reset = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    check("abort_no_done_diff", int'(diff), 0);
    run_op(8'd20, 8'd5, 8'd15, 1'b0, 1'b1);
    wait_drain();

    // Back-to-back with start held high; operands change at each accept
    wait_idle();
    start = 1'b1;
    in1   = 8'd7;
    in2   = 8'd2;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) @(posedge clk);
      else repeat (WIDTH + 2) @(posedge clk);
      #1;
      e.d   = in1 - in2;
      e.b   = (in1 < in2);
      e.acc = cyc;
      exp_q.push_back(e);
      case (i)
        0:       begin in1 = 8'd2; in2 = 8'd7; end
        1:       begin in1 = 8'd0; in2 = 8'd0; end
        default: start = 1'b0;
      endcase
    end
    wait_drain();
    repeat (WIDTH + 4) @(negedge clk);

    check("done_count",    done_cnt,       11);
    check("queue_empty",   exp_q.size(),   0);
    check("final_diff",    int'(diff),     0);
    check("final_borrow",  int'(borrow),   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
